// File: rtl/shared_dmem_responder.sv
// Memory-side responder for the dual-core data-memory interface: round-robin
// arbitration between Core0/Core1, one access at a time, fixed access latency.
module shared_dmem_responder #(
  parameter int DEPTH     = 1024,
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        C0_Req,
  input  logic        C0_Write,
  input  logic [31:0] C0_Addr,
  input  logic [31:0] C0_WData,
  output logic        C0_Ready,
  output logic [31:0] C0_RData,
  input  logic        C1_Req,
  input  logic        C1_Write,
  input  logic [31:0] C1_Addr,
  input  logic [31:0] C1_WData,
  output logic        C1_Ready,
  output logic [31:0] C1_RData,
  output logic        Busy
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                 state_q;
  logic                   pri_q;      // 0: Core0 wins a tie, 1: Core1 wins
  logic                   owner_q;
  logic                   write_q;
  logic                   oor_q;
  logic [ADDR_BITS-1:0]   idx_q;
  logic [31:0]            wdata_q;
  logic [CW-1:0]          cnt_q;

  logic [31:0]            mem [DEPTH];

  logic                   gnt_d;
  logic [31:0]            sel_addr;
  logic                   access_now;
  logic [31:0]            rd_word;
  logic                   unused_addr_lsbs;

  assign gnt_d      = (C0_Req && C1_Req) ? pri_q : C1_Req;
  assign sel_addr   = gnt_d ? C1_Addr : C0_Addr;
  assign access_now = (state_q == ACCESS) && (cnt_q == '0);
  assign rd_word    = oor_q ? 32'd0 : mem[idx_q];
  assign unused_addr_lsbs = ^sel_addr[1:0];

  // Write is gated by Reset so a reset landing on the access edge commits nothing.
  always_ff @(posedge Clk) begin
    if (!Reset && access_now && write_q && !oor_q)
      mem[idx_q] <= wdata_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      pri_q    <= 1'b0;
      owner_q  <= 1'b0;
      write_q  <= 1'b0;
      oor_q    <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      C0_Ready <= 1'b0;
      C1_Ready <= 1'b0;
      C0_RData <= '0;
      C1_RData <= '0;
      Busy     <= 1'b0;
    end else begin
      C0_Ready <= 1'b0;
      C1_Ready <= 1'b0;
      case (state_q)
        IDLE: begin
          if (C0_Req || C1_Req) begin
            owner_q <= gnt_d;
            pri_q   <= ~gnt_d;
            write_q <= gnt_d ? C1_Write : C0_Write;
            wdata_q <= gnt_d ? C1_WData : C0_WData;
            idx_q   <= sel_addr[ADDR_BITS+1:2];
            oor_q   <= |sel_addr[31:ADDR_BITS+2];
            cnt_q   <= CW'(LATENCY - 1);
            state_q <= ACCESS;
            Busy    <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            if (!write_q) begin
              if (owner_q) C1_RData <= rd_word;
              else         C0_RData <= rd_word;
            end
            if (owner_q) C1_Ready <= 1'b1;
            else         C0_Ready <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
          Busy    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
